// File: rtl/dma_copy_engine_pkg.sv
// Shared constants for the DMA copy engine: register offsets (mem_addr[3:2]),
// CTRL/STATUS bit positions and the master FSM state encoding.
package dma_copy_engine_pkg;

  // Register offsets as seen on mem_addr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_ABORT    = 2;

  // STATUS read bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // Master FSM states. Each of READ/WRITE spends one cycle with m_valid low
  // before raising the request, which gives the idle gap between transactions.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-copy DMA engine: a slave register file (SRC, DST, LEN, CTRL/STATUS)
// and a master FSM that copies LEN words from SRC to DST, one read then one
// write per word.
//
// Handshakes: slave side accepts a request in any cycle where enable and
// mem_valid are high and mem_ready is low; mem_ready pulses for one cycle
// on the following cycle. Master side raises m_valid with stable
// m_addr/m_wdata/m_wstrb and holds them until the cycle m_ready is high; that
// edge completes the transaction and m_valid drops for at least one cycle.
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq,
  output dma_state_e  dbg_state
);

  logic [31:0]      src_reg;
  logic [31:0]      dst_reg;
  logic [LEN_W-1:0] len_reg;

  dma_state_e       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      buffer;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             abort_pend;

  logic             slave_acc;
  logic             slave_wr;
  logic             ctrl_wr;
  logic             start_req;
  logic             clr_req;
  logic             abort_req;
  logic [31:0]      rd_mux;
  logic             addr_unused;

  assign slave_acc = enable && mem_valid && !mem_ready;
  assign slave_wr  = slave_acc && (mem_wstrb != 4'h0);
  assign ctrl_wr   = slave_wr && (mem_addr[3:2] == REG_CTRL);
  assign start_req = ctrl_wr && mem_wdata[CTRL_START];
  assign clr_req   = ctrl_wr && mem_wdata[CTRL_CLR_DONE];
  assign abort_req = ctrl_wr && mem_wdata[CTRL_ABORT] && busy;

  // Register offsets are word aligned; the byte offset bits carry no meaning.
  assign addr_unused = ^mem_addr[1:0];

  assign irq       = done;
  assign dbg_state = state;

  // Read data selection for slave reads
  always_comb begin
    rd_mux = 32'h0;
    case (mem_addr[3:2])
      REG_SRC:  rd_mux = src_reg;
      REG_DST:  rd_mux = dst_reg;
      REG_LEN:  rd_mux = 32'(len_reg);
      REG_CTRL: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = done;
        rd_mux[STAT_ABORTED] = aborted;
      end
      default:  rd_mux = 32'h0;
    endcase
  end

  // Slave register file: configuration writes, read capture and the ack pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_reg   <= 32'h0;
      dst_reg   <= 32'h0;
      len_reg   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= slave_acc;
      if (slave_wr) begin
        mem_rdata <= 32'h0;
        // Configuration is frozen while a copy runs; the write is still acked.
        if (!busy) begin
          case (mem_addr[3:2])
            REG_SRC: src_reg <= {mem_wdata[31:2], 2'b00};
            REG_DST: dst_reg <= {mem_wdata[31:2], 2'b00};
            REG_LEN: len_reg <= mem_wdata[LEN_W-1:0];
            default: ;
          endcase
        end
      end else if (slave_acc) begin
        mem_rdata <= rd_mux;
      end
    end
  end

  // Master FSM with status flags; later assignments give DONE-set priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      src_ptr    <= 32'h0;
      dst_ptr    <= 32'h0;
      cnt        <= '0;
      buffer     <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      m_wstrb    <= 4'h0;
    end else begin
      if (clr_req) begin
        done <= 1'b0;
      end
      if (abort_req) begin
        abort_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_req && !busy) begin
            src_ptr    <= src_reg;
            dst_ptr    <= dst_reg;
            cnt        <= len_reg;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (len_reg == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_addr  <= src_ptr;
            m_wstrb <= 4'h0;
          end else if (m_ready) begin
            buffer  <= m_rdata;
            m_valid <= 1'b0;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_addr  <= dst_ptr;
            m_wdata <= buffer;
            m_wstrb <= 4'hF;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            src_ptr <= src_ptr + 32'd4;
            dst_ptr <= dst_ptr + 32'd4;
            cnt     <= cnt - LEN_W'(1);
            if ((cnt == LEN_W'(1)) || abort_pend || abort_req) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              aborted    <= abort_pend || abort_req;
              abort_pend <= 1'b0;
            end else begin
              state <= ST_READ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a word memory model on the master
// port (configurable wait states) and a transaction log.
module tb_dma_copy_engine;
  import dma_copy_engine_pkg::*;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        irq;
  dma_state_e  dbg_state;

  int total = 0;
  int bad   = 0;

  dma_copy_engine #(.LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .m_ready(m_ready), .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and monitor ----------------
  logic [31:0] ram [256];
  int          max_wait   = 0;
  bit          fixed_wait = 0;
  bit          pending    = 0;
  int          wait_left  = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_wstrb;
  int          stab_err   = 0;
  int          mv_cycles  = 0;
  int          wr_done    = 0;
  logic [31:0] tq_addr [$];
  logic [31:0] tq_data [$];
  logic [3:0]  tq_strb [$];
  logic [31:0] exp_q   [$];

  always @(negedge clk) begin
    if (!resetn) begin
      m_ready = 1'b0;
      pending = 0;
    end else if (m_valid) begin
      if (!pending) begin
        pending    = 1;
        wait_left  = fixed_wait ? max_wait : int'($urandom_range(0, max_wait));
        hold_addr  = m_addr;
        hold_wdata = m_wdata;
        hold_wstrb = m_wstrb;
      end else if (m_addr !== hold_addr || m_wdata !== hold_wdata || m_wstrb !== hold_wstrb) begin
        stab_err++;
      end
      if (wait_left == 0) begin
        m_ready = 1'b1;
        if (m_wstrb == 4'h0) m_rdata = ram[m_addr[9:2]];
      end else begin
        wait_left--;
        m_ready = 1'b0;
      end
    end else begin
      m_ready = 1'b0;
      pending = 0;
    end
  end

  always @(posedge clk) begin
    if (resetn && m_valid) mv_cycles++;
    if (resetn && m_valid && m_ready) begin
      tq_addr.push_back(m_addr);
      tq_strb.push_back(m_wstrb);
      if (m_wstrb == 4'h0) begin
        tq_data.push_back(m_rdata);
      end else begin
        tq_data.push_back(m_wdata);
        ram[m_addr[9:2]] = m_wdata;
        wr_done++;
      end
    end
  end

  // ---------------- slave driver tasks (enter and leave at a negedge) ----------------
  task automatic bus_access(input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
    if (mem_ready) @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL slave_ack addr=%h: mem_ready=%b want 1", addr, mem_ready);
    end
    rdata     = mem_rdata;
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_access(addr, wdata, 4'hF, dummy);
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata);
    bus_access(addr, 32'h0, 4'h0, rdata);
  endtask

  task automatic clear_log();
    tq_addr.delete();
    tq_data.delete();
    tq_strb.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    resetn = 1'b0; enable = 1'b0; mem_valid = 1'b0;
    mem_addr = 4'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0; m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata, irq} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: m_valid=%b m_addr=%h m_wdata=%h m_wstrb=%h mem_ready=%b mem_rdata=%h irq=%b want all 0",
               m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata, irq);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    resetn = 1'b1;
    @(negedge clk);
    bus_read(4'hC, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", r); end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    bus_write(4'h0, 32'h1234_5677);
    bus_write(4'h4, 32'hFFFF_FFFF);
    bus_write(4'h8, 32'hABCD_1234);
    bus_read(4'h0, r);
    total++;
    if (r !== 32'h1234_5674) begin bad++; $display("FAIL src_align: got %h want 12345674", r); end
    bus_read(4'h4, r);
    total++;
    if (r !== 32'hFFFF_FFFC) begin bad++; $display("FAIL dst_align: got %h want fffffffc", r); end
    bus_read(4'h8, r);
    total++;
    if (r !== 32'h0000_1234) begin bad++; $display("FAIL len_zext: got %h want 00001234", r); end
  endtask

  task automatic test_handshake();
    // Hold the request for three edges: accept, blocked by mem_ready, accept.
    logic [2:0] seen;
    if (mem_ready) @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 4'hC; mem_wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = mem_ready;
    end
    enable = 1'b0; mem_valid = 1'b0;
    total++;
    if (seen !== 3'b101) begin bad++; $display("FAIL ack_pulse: got %b want 101", seen); end
    @(negedge clk);
    total++;
    if (mem_ready !== 1'b0) begin bad++; $display("FAIL ack_drop: got %b want 0", mem_ready); end
  endtask

  task automatic test_copy_basic();
    logic [31:0] r;
    logic [31:0] d [3];
    int cyc;
    d[0] = 32'hA5A5_0001; d[1] = 32'h5A5A_0002; d[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin ram[64 + i] = d[i]; ram[128 + i] = 32'h0; end
    max_wait = 0; fixed_wait = 0;
    bus_write(4'h0, 32'h100);
    bus_write(4'h4, 32'h200);
    bus_write(4'h8, 32'd3);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h100 + 32'(4 * i));
      exp_q.push_back(32'h200 + 32'(4 * i));
    end
    bus_write(4'hC, 32'h1);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    total++;
    if (cyc != 12) begin bad++; $display("FAIL basic_latency: got %0d cycles want 12", cyc); end
    total++;
    if (tq_addr.size() != 6) begin bad++; $display("FAIL basic_txn_count: got %0d want 6", tq_addr.size()); end
    for (int i = 0; i < 6 && i < tq_addr.size(); i++) begin
      total++;
      if (tq_addr[i] !== exp_q[i] || tq_data[i] !== d[i / 2] || tq_strb[i] !== ((i % 2) ? 4'hF : 4'h0)) begin
        bad++;
        $display("FAIL basic_txn%0d: got addr=%h data=%h strb=%h want addr=%h data=%h strb=%h",
                 i, tq_addr[i], tq_data[i], tq_strb[i], exp_q[i], d[i / 2], (i % 2) ? 4'hF : 4'h0);
      end
    end
    bus_read(4'hC, r);
    total++;
    if (r !== 32'h2) begin bad++; $display("FAIL basic_status: got %h want 2", r); end
  endtask

  task automatic test_len_zero();
    logic [31:0] r;
    int mv0;
    bus_write(4'hC, 32'h2);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL done_clear: irq=%b want 0", irq); end
    bus_write(4'h8, 32'd0);
    mv0 = mv_cycles;
    bus_write(4'hC, 32'h1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL len0_done: irq=%b want 1", irq); end
    repeat (6) @(negedge clk);
    total++;
    if (mv_cycles != mv0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL len0_no_traffic: m_valid cycles=%0d state=%0d want 0 IDLE", mv_cycles - mv0, dbg_state);
    end
    // Start and clear together with LEN=0: the set from the start wins.
    bus_write(4'hC, 32'h3);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL set_wins: irq=%b want 1", irq); end
    // Start and clear together with LEN=1: old DONE clears, copy begins.
    ram[10] = 32'h0BAD_F00D;
    bus_write(4'h0, 32'h28);
    bus_write(4'h4, 32'h2C);
    bus_write(4'h8, 32'd1);
    bus_write(4'hC, 32'h3);
    bus_read(4'hC, r);
    total++;
    if (r[1:0] !== 2'b01) begin bad++; $display("FAIL start_clear: status=%h want busy=1 done=0", r); end
    for (int i = 0; i < 50 && irq !== 1'b1; i++) @(negedge clk);
    total++;
    if (irq !== 1'b1 || ram[11] !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL start_clear_copy: irq=%b dst=%h want 1 0badf00d", irq, ram[11]);
    end
  endtask

  task automatic test_wrap();
    ram[255] = 32'hCAFE_0001; ram[0] = 32'hCAFE_0002; ram[16] = 32'h0; ram[17] = 32'h0;
    max_wait = 0; fixed_wait = 0;
    bus_write(4'h0, 32'hFFFF_FFFC);
    bus_write(4'h4, 32'h40);
    bus_write(4'h8, 32'd2);
    clear_log();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h40);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h44);
    bus_write(4'hC, 32'h3);
    for (int i = 0; i < 60 && irq !== 1'b1; i++) @(negedge clk);
    total++;
    if (tq_addr.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", tq_addr.size()); end
    for (int i = 0; i < 4 && i < tq_addr.size(); i++) begin
      total++;
      if (tq_addr[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, tq_addr[i], exp_q[i]); end
    end
    total++;
    if (ram[16] !== 32'hCAFE_0001 || ram[17] !== 32'hCAFE_0002) begin
      bad++;
      $display("FAIL wrap_data: got %h %h want cafe0001 cafe0002", ram[16], ram[17]);
    end
  endtask

  task automatic test_random_wait();
    logic [31:0] d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = $urandom;
      ram[48 + i] = d[i];
      ram[56 + i] = 32'h0;
    end
    max_wait = 5; fixed_wait = 0; stab_err = 0;
    bus_write(4'h0, 32'hC0);
    bus_write(4'h4, 32'hE0);
    bus_write(4'h8, 32'd6);
    clear_log();
    bus_write(4'hC, 32'h3);
    for (int i = 0; i < 400 && irq !== 1'b1; i++) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL rand_timeout: irq=%b want 1", irq); end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL rand_stable: %0d unstable cycles want 0", stab_err); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (ram[56 + i] !== d[i]) begin bad++; $display("FAIL rand_data%0d: got %h want %h", i, ram[56 + i], d[i]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int k;
    for (int i = 0; i < 10; i++) ram[192 + i] = 32'h3000_0000 + 32'(i);
    max_wait = 3; fixed_wait = 1;
    bus_write(4'h0, 32'h300);
    bus_write(4'h4, 32'h380);
    bus_write(4'h8, 32'd10);
    bus_write(4'hC, 32'h2);
    wr_done = 0;
    bus_write(4'hC, 32'h1);
    k = 0;
    while (!(wr_done == 2 && dbg_state == ST_READ && !m_valid) && k < 300) begin @(negedge clk); k++; end
    total++;
    if (k >= 300) begin bad++; $display("FAIL abort_reach_read3: timeout want READ after 2 writes"); end
    bus_write(4'hC, 32'h4);
    bus_write(4'hC, 32'h1);
    bus_write(4'h0, 32'hDEAD_0000);
    for (int i = 0; i < 200 && irq !== 1'b1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    total++;
    if (wr_done != 3) begin bad++; $display("FAIL abort_writes: got %0d want 3", wr_done); end
    bus_read(4'hC, r);
    total++;
    if (r !== 32'h6) begin bad++; $display("FAIL abort_status: got %h want 6", r); end
    bus_read(4'h0, r);
    total++;
    if (r !== 32'h300) begin bad++; $display("FAIL busy_src_write: got %h want 300", r); end
    // Abort in IDLE changes nothing.
    bus_write(4'hC, 32'h4);
    bus_read(4'hC, r);
    total++;
    if (r !== 32'h6) begin bad++; $display("FAIL idle_abort: got %h want 6", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int k, mv0;
    max_wait = 5; fixed_wait = 1;
    bus_write(4'h0, 32'h10);
    bus_write(4'h4, 32'h30);
    bus_write(4'h8, 32'd4);
    bus_write(4'hC, 32'h1);
    k = 0;
    while (!(dbg_state == ST_WRITE && m_valid) && k < 100) begin @(negedge clk); k++; end
    total++;
    if (k >= 100) begin bad++; $display("FAIL rst_reach_write: timeout want WRITE with m_valid"); end
    resetn = 1'b0;
    #1;
    total++;
    if ({m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata, irq} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: m_valid=%b m_addr=%h m_wdata=%h m_wstrb=%h irq=%b want all 0",
               m_valid, m_addr, m_wdata, m_wstrb, irq);
    end
    @(negedge clk);
    resetn = 1'b1;
    mv0 = mv_cycles;
    repeat (10) @(negedge clk);
    total++;
    if (mv_cycles != mv0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL rst_mid_idle: m_valid cycles=%0d state=%0d want 0 IDLE", mv_cycles - mv0, dbg_state);
    end
    bus_read(4'hC, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL rst_mid_status: got %h want 0", r); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_regs();
    test_handshake();
    test_copy_basic();
    test_len_zero();
    test_wrap();
    test_random_wait();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter LEN_W, default 16: width of the word-count register.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  slave select from the bus decoder for this peripheral's slot.
REQ-005 mem_valid  input  1  slave request valid.
REQ-006 mem_addr  input  4  slave register offset; bits [3:2] used.
REQ-007 mem_wdata  input  32  slave write data.
REQ-008 mem_wstrb  input  4  slave write strobes; nonzero means write, zero means read.
REQ-009 mem_rdata  output  32  slave read data.
REQ-010 mem_ready  output  1  slave completion pulse.
REQ-011 m_valid  output  1  master request valid.
REQ-012 m_addr  output  32  master word address; bits [1:0] always 0.
REQ-013 m_wdata  output  32  master write data.
REQ-014 m_wstrb  output  4  master strobes: 4'h0 for reads, 4'hF for writes.
REQ-015 m_rdata  input  32  master read data, valid with m_ready.
REQ-016 m_ready  input  1  master completion.
REQ-017 irq  output  1  level, high while the DONE flag is set.

Function
REQ-018 Register map: 0x0 SRC, 0x4 DST, 0x8 LEN (LEN_W bits, zero-extended on read), 0xC CTRL/STATUS.
REQ-019 CTRL write effects:
- bit0=1 starts a copy.
- bit1=1 clears DONE.
- bit2=1 requests an abort.
REQ-020 STATUS read: bit0 BUSY, bit1 DONE, bit2 ABORTED; other bits 0.
REQ-021 Slave access completes when enable and mem_valid are both high.
- mem_ready pulses high for exactly one cycle, 1 cycle after the request.
- The request is not re-accepted while mem_ready is high.
REQ-022 Writes to SRC/DST/LEN while BUSY are ignored but still acknowledged; SRC/DST writes store bits [31:2] and force bits [1:0] to 0.
REQ-023 FSM states:
- IDLE; READ: m_valid=1, m_wstrb=0, m_addr=src_ptr.
- WRITE: m_valid=1, m_wstrb=F, m_addr=dst_ptr, m_wdata=buffer.
REQ-024 Start in IDLE:
- Copy SRC, DST and LEN into working pointers and a working count.
- Set BUSY, clear ABORTED.
- If LEN=0: set DONE immediately, no bus traffic, remain IDLE.
- Otherwise go to READ on the next cycle.
REQ-025 READ with m_ready=1: capture m_rdata into the buffer, go to WRITE.
REQ-026 WRITE with m_ready=1:
- Advance both pointers by 4, modulo 2^32, so pointers wrap silently.
- Decrement the count.
- If the count reaches 0, or an abort is pending: go to IDLE, clear BUSY, set DONE.
- Otherwise go to READ.
REQ-027 Master request outputs (m_addr, m_wdata, m_wstrb) hold stable while m_valid=1 and m_ready=0; m_valid never deasserts before m_ready.
REQ-028 m_valid is low for at least one cycle between transactions.
REQ-029 Abort handling:
- Abort while BUSY sets a pending flag.
- The transfer ends at the next WRITE completion and sets ABORTED.
- Abort while in READ still completes the current read and its write.
- Abort in IDLE has no effect.
REQ-030 A start while BUSY is ignored.
REQ-031 A start together with a DONE clear in the same write clears the old DONE and begins the new copy.
REQ-032 If a start and a DONE-set event coincide, set wins.
REQ-033 Slave register accesses are serviced in every FSM state without stalling the master side.
REQ-034 Throughput: 2 transactions per word plus 1 idle cycle each; with zero-wait m_ready, 4 cycles per word.

Reset
REQ-035 resetn low asynchronously forces:
- State IDLE; SRC, DST, LEN, pointers, count and buffer to 0.
- BUSY, DONE, ABORTED and the abort-pending flag to 0.
- m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0, mem_ready=0, mem_rdata=0, irq=0.
REQ-036 Reset mid-transfer abandons the outstanding master request; nothing is retried after reset releases.

Structure
REQ-037 A shared package holds:
- The register offset constants.
- The CTRL/STATUS bit-position constants.
- The FSM state encoding.
REQ-038 Single module, no sub-modules; the slave register file and the master FSM are separate always blocks.

Verification
REQ-039 LEN=3, SRC=0x100, DST=0x200, memory model with zero wait states:
- Expect reads at 0x100, 0x104 and 0x108, each followed by a write of the same data to 0x200, 0x204 and 0x208.
- Then DONE=1, irq=1, 12 cycles from start to DONE.
REQ-040 Memory model with random 0–5 wait states: m_addr, m_wdata and m_wstrb are stable until m_ready; the data copied is bit-exact.
REQ-041 LEN=0 start: no m_valid ever, DONE=1 one cycle after the CTRL write.
REQ-042 SRC=0xFFFFFFFC, LEN=2: second read at 0x00000000 (wrap).
REQ-043 LEN=10 with abort written during the 3rd READ:
- Exactly 3 writes complete.
- STATUS reads 0b110 (DONE, ABORTED).
- A start during BUSY is ignored.
REQ-044 resetn pulsed low while m_valid=1 in WRITE: all outputs are 0 immediately, and the engine stays IDLE after release.
